// File: rtl/seg4_to_int.sv
`default_nettype none
// ============================================================================
//  Module   : seg4_to_int
//  Brief    : Converts four active-low 7-segment digit patterns (thousands
//             down to units) into a 16-bit binary integer, one digit per
//             clock, with a per-digit error mask for unrecognised patterns.
//  Revision : 1.0  initial release
// ============================================================================
module seg4_to_int (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seg_in,
    input  logic        load,
    output logic        busy,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic [3:0]  err_digit
);

    // Controller states.
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_CONV = 1'b1;

    // Index of the last digit processed (units).
    localparam logic [1:0] c_LAST_IDX = 2'd3;

    // Map one active-low pattern to {unrecognised, digit}. A blanked digit
    // (all segments off) reads as zero and is not an error; anything else
    // outside the table, including a good digit with its dp lit, is an error.
    function automatic logic [4:0] seg_decode(input logic [7:0] pat);
        case (pat)
            8'hC0:   seg_decode = 5'h00;
            8'hF9:   seg_decode = 5'h01;
            8'hA4:   seg_decode = 5'h02;
            8'hB0:   seg_decode = 5'h03;
            8'h99:   seg_decode = 5'h04;
            8'h92:   seg_decode = 5'h05;
            8'h82:   seg_decode = 5'h06;
            8'hD8:   seg_decode = 5'h07;
            8'h80:   seg_decode = 5'h08;
            8'h90:   seg_decode = 5'h09;
            8'hFF:   seg_decode = 5'h00;
            default: seg_decode = 5'h10;
        endcase
    endfunction

    logic [0:0]  r_state;
    logic [31:0] r_shadow;   // captured patterns; current digit is always [31:24]
    logic [1:0]  r_idx;
    logic [13:0] r_acc;      // 9999 fits in 14 bits, so no overflow handling
    logic [3:0]  r_mask;     // shifts left as digits arrive, thousands ends at bit3

    logic [4:0]  w_dec;
    logic [3:0]  w_digit;
    logic        w_bad;
    logic [13:0] w_next_acc;
    logic [3:0]  w_next_mask;

    // Decode the digit at the head of the shadow and form the next partial result.
    always_comb begin
        w_dec       = seg_decode(r_shadow[31:24]);
        w_bad       = w_dec[4];
        w_digit     = w_dec[3:0];
        w_next_acc  = 14'(r_acc * 14'd10) + {10'd0, w_digit};
        w_next_mask = {r_mask[2:0], w_bad};
    end

    // Load/convert controller with registered outputs; results update only on
    // the fourth conversion edge and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_shadow  <= 32'd0;
            r_idx     <= 2'd0;
            r_acc     <= 14'd0;
            r_mask    <= 4'd0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            value     <= 16'd0;
            err       <= 1'b0;
            err_digit <= 4'd0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (load) begin
                        r_shadow <= seg_in;
                        r_idx    <= 2'd0;
                        r_acc    <= 14'd0;
                        r_mask   <= 4'd0;
                        busy     <= 1'b1;
                        r_state  <= c_CONV;
                    end
                end
                c_CONV: begin
                    // load is deliberately ignored here: no queuing.
                    r_shadow <= {r_shadow[23:0], 8'h00};
                    r_acc    <= w_next_acc;
                    r_mask   <= w_next_mask;
                    r_idx    <= r_idx + 2'd1;
                    if (r_idx == c_LAST_IDX) begin
                        value     <= {2'b00, w_next_acc};
                        err_digit <= w_next_mask;
                        err       <= |w_next_mask;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg4_to_int.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg4_to_int
//  Brief    : Directed self-checking bench for seg4_to_int.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg4_to_int;

    logic        clk;
    logic        rst_n;
    logic [31:0] seg_in;
    logic        load;
    logic        busy;
    logic [15:0] value;
    logic        valid;
    logic        err;
    logic [3:0]  err_digit;

    int n_vec;
    int n_bad;

    // Previous result, used to confirm outputs hold during a conversion.
    logic [15:0] r_prev_value;
    logic        r_prev_err;
    logic [3:0]  r_prev_mask;

    logic [7:0] c_enc [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hD8, 8'h80, 8'h90};

    seg4_to_int u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .load      (load),
        .busy      (busy),
        .value     (value),
        .valid     (valid),
        .err       (err),
        .err_digit (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Encode a 0..9999 integer, optionally blanking leading zeros.
    function automatic logic [31:0] encode(input int v, input bit blank);
        logic [31:0] p;
        int d [4];
        bit leading;
        d[0] = (v / 1000) % 10;
        d[1] = (v / 100) % 10;
        d[2] = (v / 10) % 10;
        d[3] = v % 10;
        leading = 1'b1;
        p = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (leading && d[k] == 0 && blank)
                p = {p[23:0], 8'hFF};
            else begin
                leading = 1'b0;
                p = {p[23:0], c_enc[d[k]]};
            end
        end
        return p;
    endfunction

    // Called at a falling edge; drives a load there and checks the whole
    // conversion. Returns at the falling edge inside the valid cycle, so a
    // following call issues its load on the edge that ends that cycle.
    task automatic do_conv(input string tag, input logic [31:0] seg,
                           input logic [15:0] ev, input logic ee,
                           input logic [3:0] em, input bit disturb);
        seg_in = seg;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "/busy"},  busy,  1);
            check({tag, "/valid0"}, valid, 0);
            check({tag, "/hold"},  {r_prev_err, r_prev_mask, r_prev_value},
                                   {err, err_digit, value});
            if (disturb && i == 1) begin
                seg_in = 32'h90909090;
                load   = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check({tag, "/valid"},   valid,     1);
        check({tag, "/busydn"},  busy,      0);
        check({tag, "/value"},   value,     ev);
        check({tag, "/err"},     err,       ee);
        check({tag, "/errdig"},  err_digit, em);
        r_prev_value = ev;
        r_prev_err   = ee;
        r_prev_mask  = em;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        load   = 1'b0;
        seg_in = 32'd0;
        r_prev_value = 16'd0;
        r_prev_err   = 1'b0;
        r_prev_mask  = 4'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst/busy",   busy,      0);
        check("rst/valid",  valid,     0);
        check("rst/value",  value,     0);
        check("rst/err",    err,       0);
        check("rst/errdig", err_digit, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and pattern-table vectors, issued back to back.
        do_conv("v1234", 32'hF9A4B099, 16'd1234, 1'b0, 4'b0000, 1'b0);
        do_conv("v9999", 32'h90909090, 16'd9999, 1'b0, 4'b0000, 1'b0);
        do_conv("v75",   32'hFFFFD892, 16'd75,   1'b0, 4'b0000, 1'b0);
        do_conv("vblank",32'hFFFFFFFF, 16'd0,    1'b0, 4'b0000, 1'b0);
        do_conv("v6080", 32'h82C080C0, 16'd6080, 1'b0, 4'b0000, 1'b0);
        do_conv("verr1", 32'hF900B099, 16'd1034, 1'b1, 4'b0100, 1'b0);
        do_conv("verr2", 32'hC0C0C040, 16'd0,    1'b1, 4'b0001, 1'b0);
        do_conv("vdp",   32'h79A4B099, 16'd234,  1'b1, 4'b1000, 1'b0);

        // Input change and ignored load mid-conversion.
        @(negedge clk);
        do_conv("vdist", 32'hF9A4B099, 16'd1234, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("dist/novalid", valid, 0);
            check("dist/nobusy",  busy,  0);
        end

        // Reset mid-conversion aborts with no valid pulse afterwards.
        seg_in = encode(5678, 1'b0);
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst/busy",   busy,      0);
        check("mrst/valid",  valid,     0);
        check("mrst/value",  value,     0);
        check("mrst/err",    err,       0);
        check("mrst/errdig", err_digit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        r_prev_value = 16'd0;
        r_prev_err   = 1'b0;
        r_prev_mask  = 4'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mrst/novalid", valid, 0);
            check("mrst/value0",  value, 0);
        end
        do_conv("v42", 32'hFFFF99A4, 16'd42, 1'b0, 4'b0000, 1'b0);

        // Back-to-back random values, one result every five cycles.
        for (int n = 0; n < 200; n++) begin
            int v;
            v = int'($urandom_range(9999, 0));
            do_conv("rand", encode(v, 1'($urandom_range(1, 0))), 16'(v),
                    1'b0, 4'b0000, 1'b0);
        end
        @(negedge clk);
        check("end/novalid", valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg4_to_int.md
SEG4_TO_INT -- requirements
Module: seg4_to_int

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 seg_in  input  32  four active-low 7-seg patterns: [31:24] thousands, [23:16] hundreds, [15:8] tens, [7:0] units.
REQ-005 load  input  1  conversion request, sampled on rising edge.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 value  output  16  decoded binary integer, zero-extended, held until the next result.
REQ-008 valid  output  1  one-cycle pulse marking a new value.
REQ-009 err  output  1  high if any digit of the current result was unrecognised; held with value.
REQ-010 err_digit  output  4  per-digit error mask; bit3 = thousands ... bit0 = units; held with value.

Function
REQ-011 Pattern table, exact 8-bit match: C0=0, F9=1, A4=2, B0=3, 99=4, 92=5, 82=6, D8=7, 80=8, 90=9.
REQ-012 Pattern FF (blanked digit) shall decode as 0 without error.
REQ-013 Any other pattern, including a valid digit with bit7 (dp) cleared, shall decode as 0 and set its err_digit bit.
REQ-014 FSM states: IDLE, CONV; reset state IDLE.
REQ-015 IDLE: load=1 at edge E0 -> register seg_in into an internal 32-bit shadow, digit index=0 (thousands), accumulator=0, error mask=0, state CONV, busy=1.
REQ-016 CONV: one digit per edge, thousands first; acc <= acc*10 + d; index increments.
REQ-017 At edge E4 (fourth CONV edge): value <= final acc, err_digit <= final mask, err <= OR of mask, valid <= 1, busy <= 0, state IDLE.
REQ-018 Latency: valid high in the cycle following edge E4, i.e. 4 cycles after the load edge; valid low in all other cycles.
REQ-019 busy high exactly for cycles after E0 up to and including E4's preceding cycle (4 cycles).
REQ-020 load while busy=1 shall be ignored; no queuing.
REQ-021 load sampled at the edge ending the valid cycle shall start a new conversion; maximum throughput one result per 5 cycles.
REQ-022 seg_in changes after E0 shall not affect the conversion in progress.
REQ-023 Accumulator width >= 14 bits; max result 9999; no overflow possible; value[15:14] always 0.
REQ-024 value, err, err_digit shall change only at E4; they hold the previous result during a conversion.

Reset
REQ-025 rst_n low shall immediately force: state IDLE, busy=0, valid=0, value=0, err=0, err_digit=0, shadow/acc/index cleared.
REQ-026 rst_n asserted mid-conversion shall abort it; no valid pulse shall follow deassertion.
REQ-027 After rst_n deasserts, the first load edge shall be accepted normally.

Verification
REQ-028 seg_in={F9,A4,B0,99}, load 1 cycle -> busy 4 cycles, then value=1234, valid=1 for 1 cycle, err=0, err_digit=0000.
REQ-029 seg_in={90,90,90,90} -> value=9999, err=0; seg_in={FF,FF,D8,92} -> value=75, err=0; all FF -> value=0, err=0.
REQ-030 seg_in={F9,00,B0,99} -> value=1034, err=1, err_digit=0100; next load {C0,C0,C0,40} -> value=0, err_digit=0001.
REQ-031 Load 1234; at cycle 2 change seg_in to all 90 and pulse load -> result still 1234, exactly one valid pulse.
REQ-032 Load 5678, assert rst_n low at cycle 2 for 1 cycle -> all outputs 0 immediately, no valid pulse afterwards; then load 42 ({FF,FF,99,A4}) -> value=42.
REQ-033 Back-to-back loads, 200 random values 0..9999 encoded per REQ-011 with random blanking of leading zeros -> each result equals the source value, err=0, one result per 5 cycles.
